arrival_time_propagator: RTL and testbench



---
 rtl/arrival_time_propagator.sv | 158 +++++++++++++++
 tb/tb_arrival_time_propagator.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/arrival_time_propagator.sv
// Streaming latest-arrival-time engine: consumes timing arcs in topological order and
// maintains at[to] = max(at[to], at[from] + delay), with worst tracking and node queries.
module arrival_time_propagator #(
  parameter int NODE_W = 10,
  parameter int DLY_W  = 24,
  parameter int AT_W   = 32
) (
  input  logic              CP,
  input  logic              RST,
  input  logic              clr_start,
  output logic              busy,
  input  logic              arc_valid,
  output logic              arc_ready,
  input  logic [NODE_W-1:0] arc_from,
  input  logic [NODE_W-1:0] arc_to,
  input  logic [DLY_W-1:0]  arc_delay,
  input  logic              qry_valid,
  input  logic [NODE_W-1:0] qry_node,
  output logic              rsp_valid,
  output logic [AT_W-1:0]   rsp_at,
  output logic [AT_W-1:0]   worst_at,
  output logic [NODE_W-1:0] worst_node,
  output logic              sat_flag
);

  localparam int DEPTH = 1 << NODE_W;

  typedef enum logic [1:0] {ST_CLEAR, ST_RUN, ST_DRAIN} state_t;

  state_t            state_reg, state_next;
  logic [NODE_W-1:0] sweep_reg;

  logic              s2_valid_reg;
  logic [NODE_W-1:0] s2_to_reg;
  logic [DLY_W-1:0]  s2_delay_reg;
  logic              fwd_from_reg, fwd_to_reg, fwd_qry_reg;
  logic [AT_W-1:0]   fwd_data_reg;

  logic              rsp_valid_reg;
  logic [AT_W-1:0]   rsp_hold_reg;
  logic [AT_W-1:0]   worst_at_reg;
  logic [NODE_W-1:0] worst_node_reg;
  logic              sat_reg;

  logic              arc_fire, qry_fire, enter_clear;
  logic              wr_en;
  logic [NODE_W-1:0] wr_addr;
  logic [AT_W-1:0]   wr_data;
  logic [AT_W-1:0]   from_at, to_at, rsp_live;
  logic [AT_W:0]     sum_ext;
  logic              sat_now;
  logic [AT_W-1:0]   sum_sat, s2_result;

  always_ff @(posedge CP) begin
    if (RST) state_reg <= ST_CLEAR;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    arc_ready  = 1'b0;
    unique case (state_reg)
      ST_CLEAR: if (sweep_reg == '1) state_next = ST_RUN;
      ST_RUN: begin
        arc_ready = 1'b1;
        if (clr_start) state_next = ST_DRAIN;
      end
      ST_DRAIN: if (!s2_valid_reg) state_next = ST_CLEAR;
      default:  state_next = ST_CLEAR;
    endcase
  end

  assign enter_clear = (state_reg == ST_DRAIN) && (state_next == ST_CLEAR);
  assign arc_fire    = arc_valid && arc_ready;
  assign qry_fire    = qry_valid && (state_reg == ST_RUN);
  assign busy        = (state_reg != ST_RUN) || s2_valid_reg;

  // Sweep counter idles at 0 outside CLEAR so every sweep starts from node 0.
  always_ff @(posedge CP) begin
    if (RST || state_reg != ST_CLEAR) sweep_reg <= '0;
    else                              sweep_reg <= sweep_reg + 1'b1;
  end

  assign wr_en   = (state_reg == ST_CLEAR) || s2_valid_reg;
  assign wr_addr = (state_reg == ST_CLEAR) ? sweep_reg : s2_to_reg;
  assign wr_data = (state_reg == ST_CLEAR) ? '0 : s2_result;

  // One RAM copy per read port (from, to, query); all share the single write port.
  for (genvar gi = 0; gi < 3; gi++) begin : g_bank
    logic [AT_W-1:0]   mem [DEPTH];
    logic [AT_W-1:0]   q;
    logic [NODE_W-1:0] addr;
    assign addr = (gi == 0) ? arc_from : (gi == 1) ? arc_to : qry_node;
    always_ff @(posedge CP) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      q <= mem[addr];
    end
  end

  // RAM reads are read-first, so a write landing on the read edge is forwarded.
  always_ff @(posedge CP) begin
    if (RST) begin
      s2_valid_reg <= 1'b0;
      fwd_from_reg <= 1'b0;
      fwd_to_reg   <= 1'b0;
      fwd_qry_reg  <= 1'b0;
    end else begin
      s2_valid_reg <= arc_fire;
      fwd_from_reg <= s2_valid_reg && (s2_to_reg == arc_from);
      fwd_to_reg   <= s2_valid_reg && (s2_to_reg == arc_to);
      fwd_qry_reg  <= s2_valid_reg && (s2_to_reg == qry_node);
    end
    s2_to_reg    <= arc_to;
    s2_delay_reg <= arc_delay;
    fwd_data_reg <= s2_result;
  end

  assign from_at   = fwd_from_reg ? fwd_data_reg : g_bank[0].q;
  assign to_at     = fwd_to_reg   ? fwd_data_reg : g_bank[1].q;
  assign sum_ext   = {1'b0, from_at} + (AT_W+1)'(s2_delay_reg);
  assign sat_now   = sum_ext[AT_W];
  assign sum_sat   = sat_now ? '1 : sum_ext[AT_W-1:0];
  assign s2_result = (sum_sat > to_at) ? sum_sat : to_at;

  always_ff @(posedge CP) begin
    if (RST || enter_clear) begin
      worst_at_reg   <= '0;
      worst_node_reg <= '0;
      sat_reg        <= 1'b0;
    end else if (s2_valid_reg) begin
      if (s2_result > worst_at_reg) begin
        worst_at_reg   <= s2_result;
        worst_node_reg <= s2_to_reg;
      end
      if (sat_now) sat_reg <= 1'b1;
    end
  end

  assign rsp_live = fwd_qry_reg ? fwd_data_reg : g_bank[2].q;

  // rsp_at holds the last response between queries.
  always_ff @(posedge CP) begin
    if (RST) begin
      rsp_valid_reg <= 1'b0;
      rsp_hold_reg  <= '0;
    end else begin
      rsp_valid_reg <= qry_fire;
      if (rsp_valid_reg) rsp_hold_reg <= rsp_live;
    end
  end

  assign rsp_valid  = rsp_valid_reg;
  assign rsp_at     = rsp_valid_reg ? rsp_live : rsp_hold_reg;
  assign worst_at   = worst_at_reg;
  assign worst_node = worst_node_reg;
  assign sat_flag   = sat_reg;

endmodule

// File: tb/tb_arrival_time_propagator.sv
// Bench for arrival_time_propagator: directed scenarios plus random arcs/queries,
// checked against an array-based arrival model.
module tb_arrival_time_propagator;

  localparam int     NW     = 10;
  localparam int     DW     = 24;
  localparam int     AW     = 25;
  localparam int     SWEEP  = 1 << NW;
  localparam longint AT_MAX = (longint'(1) << AW) - 1;

  logic          CP = 1'b0;
  logic          RST, clr_start, busy, arc_valid, arc_ready, qry_valid, rsp_valid, sat_flag;
  logic [NW-1:0] arc_from, arc_to, qry_node, worst_node;
  logic [DW-1:0] arc_delay;
  logic [AW-1:0] rsp_at, worst_at;

  arrival_time_propagator #(.NODE_W(NW), .DLY_W(DW), .AT_W(AW)) dut (
    .CP(CP), .RST(RST), .clr_start(clr_start), .busy(busy),
    .arc_valid(arc_valid), .arc_ready(arc_ready), .arc_from(arc_from),
    .arc_to(arc_to), .arc_delay(arc_delay), .qry_valid(qry_valid),
    .qry_node(qry_node), .rsp_valid(rsp_valid), .rsp_at(rsp_at),
    .worst_at(worst_at), .worst_node(worst_node), .sat_flag(sat_flag)
  );

  always #5 CP = ~CP;

  int     n_cmp = 0;
  int     n_bad = 0;
  longint m_at [SWEEP];
  longint m_worst;
  int     m_wnode;
  bit     m_sat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < SWEEP; i++) m_at[i] = 0;
    m_worst = 0;
    m_wnode = 0;
    m_sat   = 1'b0;
  endfunction

  function automatic void model_arc(input int f, input int t, input longint d);
    longint s;
    s = m_at[f] + d;
    if (s > AT_MAX) begin
      s     = AT_MAX;
      m_sat = 1'b1;
    end
    if (s > m_at[t]) m_at[t] = s;
    if (m_at[t] > m_worst) begin
      m_worst = m_at[t];
      m_wnode = t;
    end
  endfunction

  // One clock: offer an arc and/or query, advance, check the response.
  task automatic cycle(input bit av, input int f, input int t, input longint d,
                       input bit qv, input int qn, output bit took);
    bit     q_took;
    longint q_want;
    arc_valid = av;
    arc_from  = NW'(f);
    arc_to    = NW'(t);
    arc_delay = DW'(d);
    qry_valid = qv;
    qry_node  = NW'(qn);
    took   = av && (arc_ready === 1'b1);
    q_took = qv && (arc_ready === 1'b1);
    q_want = m_at[qn];
    if (took) model_arc(f, t, d);
    @(posedge CP); #1;
    check("rsp_valid", rsp_valid, q_took);
    if (q_took) check($sformatf("rsp_at[%0d]", qn), rsp_at, q_want);
    $display("cyc arc=%0b %0d->%0d d=0x%0h took=%0b qry=%0b n=%0d rsp=0x%0h", av, f, t, d, took, q_took, qn, rsp_at);
    arc_valid = 1'b0;
    qry_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit tk;
    repeat (n) cycle(1'b0, 0, 0, 0, 1'b0, 0, tk);
  endtask

  task automatic query_const(input string tag, input int n, input longint want);
    bit tk;
    cycle(1'b0, 0, 0, 0, 1'b1, n, tk);
    check(tag, rsp_at, want);
  endtask

  task automatic check_status(input string tag);
    check({tag, ".worst_at"},   worst_at,   m_worst);
    check({tag, ".worst_node"}, worst_node, m_wnode);
    check({tag, ".sat_flag"},   sat_flag,   m_sat);
  endtask

  // Counts busy cycles from now until RUN, probing queries the whole time.
  task automatic wait_run(input string tag, input int want);
    int n      = 0;
    int rdy_hi = 0;
    int rsp_hi = 0;
    qry_valid = 1'b1;
    while (busy !== 1'b0 && n < 4000) begin
      if (arc_ready !== 1'b0) rdy_hi++;
      if (rsp_valid !== 1'b0) rsp_hi++;
      qry_node = NW'($urandom);
      @(posedge CP); #1;
      n++;
    end
    qry_valid = 1'b0;
    if (rsp_valid !== 1'b0) rsp_hi++;
    check({tag, ".busy_cycles"}, n, want);
    check({tag, ".ready_while_busy"}, rdy_hi, 0);
    check({tag, ".rsp_outside_run"}, rsp_hi, 0);
    check({tag, ".ready_in_run"}, arc_ready, 1);
    $display("%s: busy for %0d cycles", tag, n);
  endtask

  initial begin
    bit tk;
    RST = 1'b1; clr_start = 1'b0; arc_valid = 1'b0; qry_valid = 1'b0;
    arc_from = '0; arc_to = '0; arc_delay = '0; qry_node = '0;
    model_clear();

    @(posedge CP); #1;
    RST = 1'b0;
    check("rst.busy", busy, 1);
    check("rst.arc_ready", arc_ready, 0);
    check("rst.rsp_valid", rsp_valid, 0);
    check("rst.rsp_at", rsp_at, 0);
    check("rst.worst_at", worst_at, 0);
    check("rst.worst_node", worst_node, 0);
    check("rst.sat_flag", sat_flag, 0);
    wait_run("reset", SWEEP);
    query_const("rst.q5", 5, 0);

    // Dependent chain; node 2 is queried in the S2-write cycle of 1->2.
    cycle(1'b1, 0, 1, 'h04DE96, 1'b0, 0, tk);
    cycle(1'b1, 1, 2, 'h008AD3, 1'b0, 0, tk);
    query_const("chain.same_cycle_q2", 2, 'h56969);
    idle(2);
    check("chain.worst_at", worst_at, 'h56969);
    check("chain.worst_node", worst_node, 2);
    check_status("chain");

    // Clear while an arc is held valid; the in-flight arc must still land.
    clr_start = 1'b1;
    cycle(1'b1, 2, 9, 'h100000, 1'b0, 0, tk);
    clr_start = 1'b0;
    check("clear.inflight_accepted", tk, 1);
    arc_valid = 1'b1; arc_from = NW'(0); arc_to = NW'(3); arc_delay = DW'('h100);
    check("clear.ready_drop", arc_ready, 0);
    @(posedge CP); #1;
    check("clear.inflight_worst", worst_at, 'h156969);
    check("clear.inflight_node", worst_node, 9);
    wait_run("clear", SWEEP + 1);
    model_clear();
    check("clear.worst_at", worst_at, 0);
    check("clear.sat_flag", sat_flag, 0);
    cycle(1'b1, 0, 3, 'h100, 1'b0, 0, tk);
    check("clear.held_accepted", tk, 1);

    // Reconvergence and tie on worst.
    cycle(1'b1, 0, 3, 'h80, 1'b0, 0, tk);
    cycle(1'b1, 0, 4, 'h100, 1'b0, 0, tk);
    idle(2);
    query_const("reconv.q3", 3, 'h100);
    query_const("reconv.q9_cleared", 9, 0);
    check("reconv.tie_node", worst_node, 3);
    check_status("reconv");

    // Saturation at AT_W=25.
    cycle(1'b1, 5, 6, 'hFFFFFF, 1'b0, 0, tk);
    cycle(1'b1, 6, 7, 'hFFFFFF, 1'b0, 0, tk);
    cycle(1'b1, 7, 8, 'hFFFFFF, 1'b0, 0, tk);
    idle(2);
    query_const("sat.q7", 7, 'h1FFFFFE);
    query_const("sat.q8", 8, 'h1FFFFFF);
    check("sat.flag", sat_flag, 1);
    check_status("sat");

    // Random arcs on a small node set to stress forwarding and self-loops.
    model_clear();
    clr_start = 1'b1;
    cycle(1'b0, 0, 0, 0, 1'b0, 0, tk);
    clr_start = 1'b0;
    wait_run("rclear", SWEEP + 1);
    for (int b = 0; b < 30; b++) begin
      for (int c = 0; c < 20; c++) begin
        longint d;
        d = ($urandom_range(0, 15) == 0) ? longint'($urandom_range(0, 'hFFFFFF))
                                         : longint'($urandom_range(0, 'h3FFF));
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 15), d,
              $urandom_range(0, 1) == 1, $urandom_range(0, 15), tk);
      end
      idle(2);
      check_status($sformatf("rand%0d", b));
    end

    // RST in the middle of a sweep restarts it.
    clr_start = 1'b1;
    cycle(1'b0, 0, 0, 0, 1'b0, 0, tk);
    clr_start = 1'b0;
    repeat (300) begin
      @(posedge CP); #1;
    end
    RST = 1'b1;
    @(posedge CP); #1;
    RST = 1'b0;
    model_clear();
    check("rst_mid.sat_flag", sat_flag, 0);
    wait_run("rst_mid", SWEEP);
    query_const("rst_mid.q3", 3, 0);
    check_status("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
